// File: rtl/gtp_rx_deframer.sv
// Recovers K28.5-marked 5-word GTP RX frames into a 40-bit strobe and an MSB-first byte FIFO stream.
// Frame strobe 1 cycle after the last word; bytes follow 1 cycle later and stall on fifo_full. GTP_RX_STRICT_PAD_EN also checks pad bytes.
module gtp_rx_deframer #(
    parameter logic [7:0] COMMA = 8'hBC,
    parameter logic [7:0] PAD   = 8'h00
) (
    input  logic        gt_rxusrclk_in,
    input  logic        reset_in,
    input  logic [15:0] gt_rxdata,
    input  logic [1:0]  gt_rxcharisk,
    output logic [39:0] frame_data,
    output logic        frame_valid,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    input  logic        fifo_full,
    output logic [23:0] frame_count,
    output logic [7:0]  err_count,
    output logic [7:0]  ovf_count
);

`ifdef GTP_RX_STRICT_PAD_EN
    localparam bit STRICT_PAD = 1'b1;
`else
    localparam bit STRICT_PAD = 1'b0;
`endif

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        W1   = 3'd1,
        W2   = 3'd2,
        W3   = 3'd3,
        W4   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [39:0] acc_q, acc_d;
    logic [39:0] frame_data_q, frame_data_d;
    logic        frame_valid_q, frame_valid_d;
    logic [23:0] frame_count_q, frame_count_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [7:0]  ovf_count_q, ovf_count_d;
    logic [39:0] shreg_q, shreg_d;
    logic [2:0]  rem_q, rem_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [7:0]  rx_byte;
    logic        pad_ok;
    logic        is_comma;
    logic        is_payload;
    logic        frame_done;
    logic        frame_err;
    logic        emit;
    logic        load_ok;
    logic [39:0] frame_word;

    assign rx_byte    = gt_rxdata[15:8];
    assign pad_ok     = !STRICT_PAD || (gt_rxdata[7:0] == PAD);
    assign is_comma   = (gt_rxcharisk == 2'b01) && (gt_rxdata[7:0] == COMMA);
    assign is_payload = (gt_rxcharisk == 2'b00) && pad_ok;
    // The last byte comes straight from the wire so the frame can complete on this edge.
    assign frame_word = {acc_q[39:8], rx_byte};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    acc_d   = {rx_byte, 32'h0};
                    state_d = W1;
                end
            end
            W1, W2, W3, W4: begin
                if (is_payload) begin
                    case (state_q)
                        W1: begin
                            acc_d[31:24] = rx_byte;
                            state_d      = W2;
                        end
                        W2: begin
                            acc_d[23:16] = rx_byte;
                            state_d      = W3;
                        end
                        W3: begin
                            acc_d[15:8] = rx_byte;
                            state_d     = W4;
                        end
                        default: begin
                            acc_d[7:0] = rx_byte;
                            frame_done = 1'b1;
                            state_d    = HUNT;
                        end
                    endcase
                end else if (is_comma) begin
                    frame_err = 1'b1;
                    acc_d     = {rx_byte, 32'h0};
                    state_d   = W1;
                end else begin
                    frame_err = 1'b1;
                    state_d   = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Serialiser: a frame may replace the last pending byte on the edge that emits it.
    assign emit    = (rem_q != 3'd0) && !fifo_full;
    assign load_ok = (rem_q == 3'd0) || ((rem_q == 3'd1) && !fifo_full);

    always_comb begin
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        ovf_count_d   = ovf_count_q;
        shreg_d       = shreg_q;
        rem_d         = rem_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;

        if (frame_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        if (emit) begin
            wr_en_d   = 1'b1;
            wr_data_d = shreg_q[39:32];
            shreg_d   = {shreg_q[31:0], 8'h00};
            rem_d     = rem_q - 3'd1;
        end

        if (frame_done) begin
            frame_data_d  = frame_word;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 24'd1;
            if (load_ok) begin
                shreg_d = frame_word;
                rem_d   = 3'd5;
            end else if (ovf_count_q != 8'hFF) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge gt_rxusrclk_in) begin
        if (reset_in) begin
            state_q       <= HUNT;
            acc_q         <= 40'h0;
            frame_data_q  <= 40'h0;
            frame_valid_q <= 1'b0;
            frame_count_q <= 24'h0;
            err_count_q   <= 8'h0;
            ovf_count_q   <= 8'h0;
            shreg_q       <= 40'h0;
            rem_q         <= 3'd0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= 8'h0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
            ovf_count_q   <= ovf_count_d;
            shreg_q       <= shreg_d;
            rem_q         <= rem_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign frame_data   = frame_data_q;
    assign frame_valid  = frame_valid_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign frame_count  = frame_count_q;
    assign err_count    = err_count_q;
    assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Bench for gtp_rx_deframer: directed scenarios plus randomized traffic against a queue-based frame model.
module tb_gtp_rx_deframer;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] PAD   = 8'h00;
`ifdef GTP_RX_STRICT_PAD_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic [15:0] gt_rxdata = 16'h0;
    logic [1:0]  gt_rxcharisk = 2'b00;
    logic        fifo_full = 1'b0;
    logic [39:0] frame_data;
    logic        frame_valid;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [23:0] frame_count;
    logic [7:0]  err_count;
    logic [7:0]  ovf_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gtp_rx_deframer #(.COMMA(COMMA), .PAD(PAD)) dut (
        .gt_rxusrclk_in(clk),
        .reset_in      (reset_in),
        .gt_rxdata     (gt_rxdata),
        .gt_rxcharisk  (gt_rxcharisk),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_full     (fifo_full),
        .frame_count   (frame_count),
        .err_count     (err_count),
        .ovf_count     (ovf_count)
    );

    // Monitor: byte log, write cycle log and frame strobe count.
    int         cyc = 0;
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         nvalid = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wlog.push_back(fifo_wr_data);
            wcyc.push_back(cyc);
        end
        if (frame_valid) nvalid++;
    end

    // Reference model: a frame is a list of collected bytes; the byte path is a list of pending bytes.
    logic [7:0]  fq[$];
    logic [7:0]  sq[$];
    logic [39:0] m_data = 40'h0;
    logic        m_valid = 1'b0;
    logic        m_wr_en = 1'b0;
    logic [7:0]  m_wr_data = 8'h0;
    logic [23:0] m_fc = 24'h0;
    logic [7:0]  m_err = 8'h0;
    logic [7:0]  m_ovf = 8'h0;
    logic        m_done, m_comma, m_pay;
    logic [39:0] m_fw;
    int          m_before;

    always @(posedge clk) begin
        if (reset_in) begin
            fq.delete(); sq.delete();
            m_data = 40'h0; m_valid = 1'b0; m_wr_en = 1'b0; m_wr_data = 8'h0;
            m_fc = 24'h0; m_err = 8'h0; m_ovf = 8'h0;
        end else begin
            m_done  = 1'b0;
            m_valid = 1'b0;
            m_fw    = 40'h0;
            m_comma = (gt_rxcharisk == 2'b01) && (gt_rxdata[7:0] == COMMA);
            m_pay   = (gt_rxcharisk == 2'b00) && (!STRICT || gt_rxdata[7:0] == PAD);
            if (fq.size() == 0) begin
                if (m_comma) fq.push_back(gt_rxdata[15:8]);
            end else if (m_pay) begin
                fq.push_back(gt_rxdata[15:8]);
                if (fq.size() == 5) begin
                    m_done = 1'b1;
                    m_fw   = {fq[0], fq[1], fq[2], fq[3], fq[4]};
                    fq.delete();
                end
            end else begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                fq.delete();
                if (m_comma) fq.push_back(gt_rxdata[15:8]);
            end
            m_before = sq.size();
            m_wr_en  = 1'b0;
            if (m_before > 0 && !fifo_full) begin
                m_wr_en   = 1'b1;
                m_wr_data = sq.pop_front();
            end
            if (m_done) begin
                m_data  = m_fw;
                m_valid = 1'b1;
                m_fc    = m_fc + 24'd1;
                if (m_before == 0 || (m_before == 1 && !fifo_full)) begin
                    sq.delete();
                    for (int i = 4; i >= 0; i--) sq.push_back(m_fw[i*8 +: 8]);
                end else if (m_ovf != 8'hFF) begin
                    m_ovf = m_ovf + 8'd1;
                end
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic full);
        @(negedge clk);
        gt_rxdata    = d;
        gt_rxcharisk = k;
        fifo_full    = full;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [39:0] f, input logic full);
        drive({f[39:32], COMMA}, 2'b01, full);
        for (int i = 3; i >= 0; i--) drive({f[i*8 +: 8], PAD}, 2'b00, full);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_in     = 1'b1;
        gt_rxdata    = 16'h0;
        gt_rxcharisk = 2'b00;
        fifo_full    = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_in = 1'b0;
        wlog.delete();
        wcyc.delete();
        nvalid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        reset_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (frame_data !== 40'h0) begin n_err++; $display("FAIL reset_frame_data got %h want 0", frame_data); end
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
        n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
        n_vec++; if (fifo_wr_data !== 8'h0) begin n_err++; $display("FAIL reset_wr_data got %h want 0", fifo_wr_data); end
        n_vec++; if (frame_count !== 24'h0) begin n_err++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
        n_vec++; if (err_count !== 8'h0) begin n_err++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        n_vec++; if (ovf_count !== 8'h0) begin n_err++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
        @(negedge clk);
        reset_in = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        send_frame(40'h1122334455, 1'b0);
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", frame_valid); end
        n_vec++; if (frame_data !== 40'h1122334455) begin n_err++; $display("FAIL single_data got %h want 1122334455", frame_data); end
        n_vec++; if (frame_count !== 24'd1) begin n_err++; $display("FAIL single_count got %0d want 1", frame_count); end
        for (int i = 0; i < 5; i++) begin
            drive(16'h0, 2'b00, 1'b0);
            n_vec++;
            if (fifo_wr_en !== 1'b1 || fifo_wr_data !== exp_b[i]) begin
                n_err++; $display("FAIL single_byte%0d got en=%b %h want en=1 %h", i, fifo_wr_en, fifo_wr_data, exp_b[i]);
            end
        end
        drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_after_en got %b want 0", fifo_wr_en); end
        n_vec++; if (nvalid !== 1) begin n_err++; $display("FAIL single_pulses got %0d want 1", nvalid); end
    endtask

    task automatic test_resync();
        do_reset();
        drive({8'hAA, COMMA}, 2'b01, 1'b0);
        drive({8'hA1, PAD}, 2'b00, 1'b0);
        drive({8'hA2, PAD}, 2'b00, 1'b0);
        send_frame(40'h0102030405, 1'b0);
        repeat (7) drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL resync_err got %0d want 1", err_count); end
        n_vec++; if (nvalid !== 1) begin n_err++; $display("FAIL resync_pulses got %0d want 1", nvalid); end
        n_vec++; if (frame_data !== 40'h0102030405) begin n_err++; $display("FAIL resync_data got %h want 0102030405", frame_data); end
        n_vec++; if (frame_count !== 24'd1) begin n_err++; $display("FAIL resync_count got %0d want 1", frame_count); end
    endtask

    task automatic test_bad_word();
        do_reset();
        drive({8'h11, COMMA}, 2'b01, 1'b0);
        drive({8'h22, PAD}, 2'b00, 1'b0);
        drive({8'h33, PAD}, 2'b10, 1'b0);
        drive({8'h44, PAD}, 2'b00, 1'b0);
        drive({8'h55, PAD}, 2'b00, 1'b0);
        repeat (3) drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL bad_err got %0d want 1", err_count); end
        n_vec++; if (nvalid !== 0) begin n_err++; $display("FAIL bad_pulses got %0d want 0", nvalid); end
        n_vec++; if (wlog.size() !== 0) begin n_err++; $display("FAIL bad_writes got %0d want 0", wlog.size()); end
        // HUNT must have been re-entered: a clean frame now completes.
        send_frame(40'hC1C2C3C4C5, 1'b0);
        n_vec++; if (frame_valid !== 1'b1 || frame_data !== 40'hC1C2C3C4C5) begin n_err++; $display("FAIL bad_recover got %b %h want 1 c1c2c3c4c5", frame_valid, frame_data); end
    endtask

    task automatic test_pad();
        logic [7:0] exp_err;
        int         exp_nv;
        exp_err = STRICT ? 8'd1 : 8'd0;
        exp_nv  = STRICT ? 0 : 1;
        do_reset();
        drive({8'h11, COMMA}, 2'b01, 1'b0);
        drive({8'h22, PAD}, 2'b00, 1'b0);
        drive({8'h33, PAD}, 2'b00, 1'b0);
        drive({8'h44, 8'h7E}, 2'b00, 1'b0);
        drive({8'h55, PAD}, 2'b00, 1'b0);
        drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (err_count !== exp_err) begin n_err++; $display("FAIL pad_err got %0d want %0d", err_count, exp_err); end
        n_vec++; if (nvalid !== exp_nv) begin n_err++; $display("FAIL pad_pulses got %0d want %0d", nvalid, exp_nv); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        do_reset();
        send_frame(40'hA1A2A3A4A5, 1'b0);
        send_frame(40'hB1B2B3B4B5, 1'b1);
        repeat (3) drive(16'h0, 2'b00, 1'b1);
        n_vec++; if (wlog.size() !== 0) begin n_err++; $display("FAIL bp_held_writes got %0d want 0", wlog.size()); end
        n_vec++; if (ovf_count !== 8'd1) begin n_err++; $display("FAIL bp_ovf got %0d want 1", ovf_count); end
        n_vec++; if (frame_count !== 24'd2) begin n_err++; $display("FAIL bp_count got %0d want 2", frame_count); end
        repeat (8) drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (wlog.size() !== 5) begin n_err++; $display("FAIL bp_nwrites got %0d want 5", wlog.size()); end
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            n_vec++;
            if (wlog[i] !== exp_b[i]) begin n_err++; $display("FAIL bp_byte%0d got %h want %h", i, wlog[i], exp_b[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] f[3];
        logic [7:0]  exp_b[$];
        do_reset();
        for (int j = 0; j < 3; j++) begin
            f[j] = {$urandom(), $urandom()};
            for (int i = 4; i >= 0; i--) exp_b.push_back(f[j][i*8 +: 8]);
        end
        for (int j = 0; j < 3; j++) send_frame(f[j], 1'b0);
        repeat (8) drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (wlog.size() !== 15) begin n_err++; $display("FAIL b2b_nwrites got %0d want 15", wlog.size()); end
        if (wlog.size() == 15) begin
            n_vec++; if (wcyc[14] - wcyc[0] !== 14) begin n_err++; $display("FAIL b2b_span got %0d want 14", wcyc[14] - wcyc[0]); end
            for (int i = 0; i < 15; i++) begin
                n_vec++;
                if (wlog[i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_byte%0d got %h want %h", i, wlog[i], exp_b[i]); end
            end
        end
        n_vec++; if (ovf_count !== 8'd0) begin n_err++; $display("FAIL b2b_ovf got %0d want 0", ovf_count); end
        n_vec++; if (frame_count !== 24'd3) begin n_err++; $display("FAIL b2b_count got %0d want 3", frame_count); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(40'hD1D2D3D4D5, 1'b0);
        drive({8'hE1, COMMA}, 2'b01, 1'b0);
        drive({8'hE2, PAD}, 2'b00, 1'b0);
        drive({8'hE3, PAD}, 2'b00, 1'b0);
        @(negedge clk);
        reset_in     = 1'b1;
        gt_rxdata    = {8'hE4, PAD};
        gt_rxcharisk = 2'b00;
        @(posedge clk);
        #1;
        n_vec++;
        if ({frame_data, frame_valid, fifo_wr_en, fifo_wr_data, frame_count, err_count, ovf_count} !== 90'h0) begin
            n_err++; $display("FAIL midreset_outputs got data=%h v=%b en=%b wd=%h fc=%0d err=%0d ovf=%0d want all 0",
                              frame_data, frame_valid, fifo_wr_en, fifo_wr_data, frame_count, err_count, ovf_count);
        end
        @(negedge clk);
        reset_in = 1'b0;
        wlog.delete();
        nvalid = 0;
        drive({8'hE5, PAD}, 2'b00, 1'b0);
        repeat (6) drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (wlog.size() !== 0 || nvalid !== 0) begin n_err++; $display("FAIL midreset_stray got writes=%0d pulses=%0d want 0 0", wlog.size(), nvalid); end
        send_frame(40'hF1F2F3F4F5, 1'b0);
        n_vec++; if (frame_valid !== 1'b1 || frame_data !== 40'hF1F2F3F4F5) begin n_err++; $display("FAIL midreset_frame got %b %h want 1 f1f2f3f4f5", frame_valid, frame_data); end
        repeat (6) drive(16'h0, 2'b00, 1'b0);
        n_vec++; if (wlog.size() !== 5 || wlog[0] !== 8'hF1 || wlog[4] !== 8'hF5) begin n_err++; $display("FAIL midreset_bytes got n=%0d want 5 bytes f1..f5", wlog.size()); end
        n_vec++; if (frame_count !== 24'd1) begin n_err++; $display("FAIL midreset_count got %0d want 1", frame_count); end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [1:0]  k;
        logic        full;
        int          r;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 19);
            d = {8'($urandom), PAD};
            k = 2'b00;
            if (r < 3) begin
                d[7:0] = COMMA; k = 2'b01;
            end else if (r == 15) begin
                d = 16'h0;
            end else if (r == 16) begin
                k = 2'($urandom_range(1, 3));
            end else if (r == 17) begin
                d[7:0] = 8'($urandom);
            end
            full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 799) == 0) begin
                @(negedge clk);
                reset_in = 1'b1;
                drive(d, k, full);
                @(negedge clk);
                reset_in = 1'b0;
            end else begin
                drive(d, k, full);
            end
            n_vec++;
            if ({frame_data, frame_valid, fifo_wr_en, fifo_wr_data, frame_count, err_count, ovf_count} !==
                {m_data, m_valid, m_wr_en, m_wr_data, m_fc, m_err, m_ovf}) begin
                n_err++;
                $display("FAIL random_cycle%0d got data=%h v=%b en=%b wd=%h fc=%0d err=%0d ovf=%0d want data=%h v=%b en=%b wd=%h fc=%0d err=%0d ovf=%0d",
                         n, frame_data, frame_valid, fifo_wr_en, fifo_wr_data, frame_count, err_count, ovf_count,
                         m_data, m_valid, m_wr_en, m_wr_data, m_fc, m_err, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_resync();
        test_bad_word();
        test_pad();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gtp_rx_deframer.md
# gtp_rx_deframer

Receive-side counterpart of the GTP transmit framer. It watches the 16-bit GTP RX user-data stream for K28.5-marked 5-word frames, recovers each 40-bit payload and presents it as a one-cycle word strobe. It also serialises the payload MSB-first into a byte-wide FIFO write port feeding the SiTCP/host side, and keeps frame, error and overflow statistics.

## Interface
- Parameters:
  - COMMA, default 8'hBC: K-character (K28.5) expected in the low byte of the first word.
  - PAD, default 8'h00: low-byte filler expected in payload words 1–4.
- Ports:
  - gt_rxusrclk_in  in  1: RX user clock; every register uses this clock.
  - reset_in  in  1: synchronous reset, active-high.
  - gt_rxdata  in  16: GTP RX data. Bits [15:8] carry the payload byte; bits [7:0] carry the comma or the pad.
  - gt_rxcharisk  in  2: GTP K flags. 2'b01 marks a comma word.
  - frame_data  out  40: last complete payload. Word 0 byte is in [39:32]; word 4 byte is in [7:0].
  - frame_valid  out  1: one-cycle strobe, high when frame_data updates.
  - fifo_wr_en  out  1: byte FIFO write enable.
  - fifo_wr_data  out  8: byte FIFO write data.
  - fifo_full  in  1: FIFO programmable-full. It must assert with at least 1 free entry remaining.
  - frame_count  out  24: completed frames, wraps at 2^24.
  - err_count  out  8: framing errors, saturates at 8'hFF.
  - ovf_count  out  8: frames dropped by the serialiser, saturates at 8'hFF.

## Operation
- Comma word: gt_rxcharisk==2'b01 and gt_rxdata[7:0]==COMMA.
- Payload word: gt_rxcharisk==2'b00, and gt_rxdata[7:0]==PAD when the pad check is compiled in.
- Idle word (data 16'h0000, charisk 2'b00) is ignored while in HUNT.
- Framer state machine:
  - HUNT: on a comma word, latch byte [39:32] and go to W1. Any other word stays in HUNT with no error.
  - W1, W2, W3 → next state: a payload word latches its byte into [31:24], [23:16], [15:8] respectively, then advances.
  - W4: a payload word latches [7:0] and completes the frame; the next state is HUNT.
- Errors in W1–W4:
  - Comma word: err_count+1, the partial frame is discarded, the new byte is latched into [39:32], and the state goes to W1 (resync).
  - Any other non-payload word (wrong charisk, or bad pad when checked): err_count+1, the frame is discarded, the state goes to HUNT.
- Frame completion, all registered on the same edge:
  - frame_data is loaded and frame_valid pulses.
  - frame_count increments.
  - The serialiser is offered the frame.
- Serialiser: a 40-bit shift register plus a 3-bit remaining-byte count, rem.
  - Loading is allowed when rem==0, or when rem==1 and !fifo_full.
  - On load, rem becomes 5.
  - If loading is not allowed, the frame is dropped from the byte path only. frame_valid still pulses and frame_count still increments; ovf_count increments.
- Byte emit: each edge with rem!=0 and !fifo_full sets fifo_wr_en=1, fifo_wr_data=top byte, shifts left 8, and decrements rem. Otherwise fifo_wr_en=0.
- Simultaneous events:
  - A last-byte emit and a new load on the same edge are legal; the load wins the shift register.
  - err_count and ovf_count saturation is independent per counter.

## Timing
- Reset values:
  - All outputs are 0: frame_data=40'h0, frame_valid=0, fifo_wr_en=0, fifo_wr_data=8'h0, all counters 0.
  - Framer is in HUNT; rem=0.
- Reset mid-frame or mid-serialisation aborts everything. No partial byte is written after reset.
- Latency:
  - Comma sampled at edge N, back-to-back payload words at N+1..N+4, so frame_valid is high in the cycle after edge N+4.
  - First fifo_wr_en is one cycle after frame_valid; the 5 bytes are on consecutive cycles when fifo_full stays low.
- Minimum frame spacing is 5 words. Back-to-back frames at that spacing, with no backpressure, give continuous fifo_wr_en with no drops.
- fifo_full is sampled on the edge that would write. A write already registered is not retracted, hence the ≥1-entry margin requirement.
- Idle words between frames are allowed in HUNT only. An idle word in W1–W4 counts as a payload word with pad 00 (valid).

## Configuration
- Macro: GTP_RX_STRICT_PAD_EN.
- Defined: payload words also require gt_rxdata[7:0]==PAD; a mismatch is a framing error.
- Undefined: gt_rxdata[7:0] of payload words is ignored; only charisk is checked.

## Test plan
- Single frame: comma word {8'h11,BC}/01, then {22,00}, {33,00}, {44,00}, {55,00} with charisk 00 → frame_data=40'h1122334455, one frame_valid pulse, then bytes 11,22,33,44,55 on 5 consecutive writes, frame_count=1.
- Resync: comma with AA, 2 payload words, then comma with 01 and 4 payload words 02..05 → err_count=1, only frame 40'h0102030405 delivered.
- Bad word:
  - charisk=2'b10 in W2 → err_count=1, state HUNT, no frame_valid.
  - With GTP_RX_STRICT_PAD_EN, low byte 8'h7E in W3 → err_count=1; without the macro → frame accepted.
- Backpressure: hold fifo_full=1 from the first emit cycle of frame A while frame B completes → A's bytes wait, B is dropped, ovf_count=1. On release, A's 5 bytes are written intact.
- Back-to-back frames: 3 frames at 5-word spacing, fifo_full=0 → 15 consecutive fifo_wr_en cycles, ovf_count=0, frame_count=3.
- Reset: assert reset_in in W3, then release → all outputs 0. A subsequent full frame is received correctly.
